logic_op_pipe: RTL

LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

---
 rtl/logic_op_pipe.sv | 92 +++++++++
 1 files changed

// File: rtl/logic_op_pipe.sv
// Bitwise logic unit with an accumulator operand and a small result FIFO.
// Results are computed at acceptance and surface at the FIFO head one cycle later.
module logic_op_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [0:WIDTH-1]           X,
  input  logic [0:WIDTH-1]           Y,
  input  logic [2:0]                 op,
  input  logic                       acc,
  input  logic                       acc_clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [0:WIDTH-1]           Z,
  output logic                       zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic             zero;
    logic [0:WIDTH-1] z;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [0:WIDTH-1] r_acc;

  logic [0:WIDTH-1] w_b, w_res;
  logic             w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_b   = acc ? r_acc : Y;
    w_res = '0;
    case (op)
      3'b000: w_res = X & w_b;
      3'b001: w_res = X | w_b;
      3'b010: w_res = X ^ w_b;
      3'b011: w_res = ~(X | w_b);
      3'b100: w_res = ~(X & w_b);
      3'b101: w_res = ~(X ^ w_b);
      3'b110: w_res = X & ~w_b;
      default: w_res = X;
    endcase
  end

  // rst_n gates in_ready so nothing is offered as acceptable while in reset.
  assign in_ready  = rst_n && (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;
  assign Z         = out_valid ? r_mem[r_rptr].z    : '0;
  assign zero      = out_valid ? r_mem[r_rptr].zero : 1'b0;

  // Storage needs no reset: occupancy masks stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{zero: (w_res == '0), z: w_res};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_acc   <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // An accepted op wins over a clear request in the same cycle.
      if (w_push)       r_acc <= w_res;
      else if (acc_clr) r_acc <= '0;
    end
  end

endmodule
